kernel_cc_start_arbiter: RTL and testbench

Round-robin scheduler that merges the start-token FIFOs of NUM_REQ upstream dataflow producers into the single shared write_back process. It pops one token from the winning producer's start FIFO and drives the write_back ap_start/ap_ready handshake. It tracks outstanding jobs in an in-order ID queue and returns a per-job completion tagged with the originating requester ID.

---
 rtl/kernel_cc_start_arbiter_pkg.sv | 41 ++++
 rtl/kernel_cc_start_arbiter_idq.sv | 48 ++++
 rtl/kernel_cc_start_arbiter.sv | 94 +++++++++
 tb/tb_kernel_cc_start_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_cc_start_arbiter_pkg.sv
// Shared constants, FSM encoding and round-robin select for the write_back start arbiter.
package kernel_cc_start_arbiter_pkg;

  // Widest requester vector the select function handles.
  localparam int MAX_REQ = 8;

  // FSM encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_START = 1'b1;

  // Derived widths.
  function automatic int id_width(input int num_req);
    return $clog2(num_req);
  endfunction

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out) + 1;
  endfunction

  // Round-robin pick: first set bit of req at last+1, last+2, ... modulo n.
  // Result is only meaningful when some req bit below n is set.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [3:0]         n,
                                         input logic [2:0]         last);
    logic [4:0] s;
    logic [2:0] win;
    logic       found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      s = 5'(last) + 5'(k);
      if (s >= 5'(n)) s = s - 5'(n);
      if (k <= int'(n) && s[4:3] == 2'b00 && !found && req[s[2:0]]) begin
        found = 1'b1;
        win   = s[2:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/kernel_cc_start_arbiter_idq.sv
// In-order requester ID queue: shift register (newest at entry 0) plus head
// pointer derived from the occupancy count. Push and pop may coincide.
module kernel_cc_start_arbiter_idq #(
  parameter int W         = 2,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        head;
  logic                    do_push, do_pop;

  assign full    = (count == CNT_WIDTH'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Oldest entry sits at count-1; a simultaneous push shifts it to count-1 of the new contents.
  assign head    = PTR_W'(count - CNT_WIDTH'(1));
  assign dout    = empty ? '0 : mem[head];

  // Shift storage on push, track occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem   <= '0;
      count <= '0;
    end else begin
      if (do_push) mem <= {mem[DEPTH-2:0], din};
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kernel_cc_start_arbiter.sv
// Round-robin merge of producer start FIFOs into one write_back ap_start/ap_ready
// handshake, with in-order completion tagging by requester ID.
module kernel_cc_start_arbiter
  import kernel_cc_start_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ID_WIDTH        = id_width(NUM_REQ),
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_empty_n,
  output logic [NUM_REQ-1:0]   req_read,
  output logic                 wb_ap_start,
  input  logic                 wb_ap_ready,
  input  logic                 wb_ap_done,
  output logic [ID_WIDTH-1:0]  grant_id,
  output logic                 done_valid,
  output logic [ID_WIDTH-1:0]  done_id,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                 err_spurious_done
);

  logic [0:0]          state;
  logic [ID_WIDTH-1:0] last_grant;
  logic [MAX_REQ-1:0]  req_ext;
  logic [2:0]          win;
  logic                issue, accept, done_ok;
  logic                q_full, q_empty;
  logic [ID_WIDTH-1:0] q_dout;

  assign req_ext     = MAX_REQ'(req_empty_n);
  assign win         = rr_pick(req_ext, 4'(NUM_REQ), 3'(last_grant));
  // Gated by reset_n so no FIFO is popped while reset is held.
  assign issue       = reset_n && (state == ST_IDLE) && (|req_empty_n) && !q_full;
  assign accept      = (state == ST_START) && wb_ap_ready;
  assign done_ok     = wb_ap_done && !q_empty;
  assign wb_ap_start = (state == ST_START);

  // One-hot pop of the winning producer FIFO in the issue cycle.
  always_comb begin
    req_read = '0;
    for (int i = 0; i < NUM_REQ; i++) req_read[i] = issue && (win == 3'(i));
  end

  // Start FSM: pop token in IDLE, hold ap_start until write_back accepts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: if (issue) begin
          state      <= ST_START;
          grant_id   <= ID_WIDTH'(win);
          last_grant <= ID_WIDTH'(win);
        end
        default: if (accept) state <= ST_IDLE;
      endcase
    end
  end

  // Completion pulse and sticky spurious-done flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_valid        <= 1'b0;
      done_id           <= '0;
      err_spurious_done <= 1'b0;
    end else begin
      done_valid <= done_ok;
      if (done_ok) done_id <= q_dout;
      if (wb_ap_done && q_empty) err_spurious_done <= 1'b1;
    end
  end

  kernel_cc_start_arbiter_idq #(
    .W         (ID_WIDTH),
    .DEPTH     (MAX_OUTSTANDING),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_idq (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .pop     (done_ok),
    .din     (grant_id),
    .dout    (q_dout),
    .count   (outstanding),
    .full    (q_full),
    .empty   (q_empty)
  );

endmodule

// File: tb/tb_kernel_cc_start_arbiter.sv
// Bench for kernel_cc_start_arbiter: vector table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_kernel_cc_start_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int MAX = 4;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_empty_n = '0;
  logic [N-1:0]   req_read;
  logic           wb_ap_start;
  logic           wb_ap_ready = 1'b0;
  logic           wb_ap_done = 1'b0;
  logic [IDW-1:0] grant_id;
  logic           done_valid;
  logic [IDW-1:0] done_id;
  logic [CW-1:0]  outstanding;
  logic           err_spurious_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kernel_cc_start_arbiter #(
    .NUM_REQ(N), .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAX), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_empty_n(req_empty_n), .req_read(req_read),
    .wb_ap_start(wb_ap_start), .wb_ap_ready(wb_ap_ready), .wb_ap_done(wb_ap_done),
    .grant_id(grant_id), .done_valid(done_valid), .done_id(done_id),
    .outstanding(outstanding), .err_spurious_done(err_spurious_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a start-pending flag, a job queue of IDs and a rotating pointer.
  bit m_start, m_dv, m_err;
  int m_gid, m_last, m_did;
  int m_q[$];

  task automatic model_reset();
    m_start = 0; m_dv = 0; m_err = 0;
    m_gid = 0; m_did = 0; m_last = N - 1;
    m_q.delete();
  endtask

  function automatic int model_winner(input logic [N-1:0] r);
    if (m_start || r == 0 || m_q.size() >= MAX) return -1;
    for (int k = 1; k <= N; k++)
      if (r[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  task automatic model_check();
    int w;
    logic [N-1:0] er;
    w  = model_winner(req_empty_n);
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_read", 32'(req_read), 32'(er));
    chk("wb_ap_start", 32'(wb_ap_start), 32'(m_start));
    if (m_start) chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("done_valid", 32'(done_valid), 32'(m_dv));
    if (m_dv) chk("done_id", 32'(done_id), 32'(m_did));
    chk("outstanding", 32'(outstanding), 32'(m_q.size()));
    chk("err_spurious", 32'(err_spurious_done), 32'(m_err));
  endtask

  task automatic model_step();
    int w;
    w = model_winner(req_empty_n);
    m_dv = 0;
    if (wb_ap_done) begin
      if (m_q.size() > 0) begin
        m_dv  = 1;
        m_did = m_q.pop_front();
      end else m_err = 1;
    end
    if (m_start) begin
      if (wb_ap_ready) begin
        m_q.push_back(m_gid);
        m_start = 0;
      end
    end else if (w >= 0) begin
      m_start = 1; m_gid = w; m_last = w;
    end
  endtask

  // One cycle: drive at negedge, check 1 time unit later, advance the model.
  task automatic cyc(input logic [N-1:0] r, input logic y, input logic d);
    @(negedge clk);
    req_empty_n = r; wb_ap_ready = y; wb_ap_done = d;
    #1;
    model_check();
    model_step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_empty_n = '0; wb_ap_ready = 1'b0; wb_ap_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]   req;
    logic           rdy, dn;
    logic [N-1:0]   rd;
    logic           st;
    logic [IDW-1:0] gid;
    logic           dv;
    logic [IDW-1:0] did;
    logic [CW-1:0]  outs;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // All requesters busy, ready immediately: grants 0,1,2,3, stall at 4 outstanding, then 0.
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0};
    tbl[1]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd0};
    tbl[2]  = '{4'hF, 1'b1, 1'b0, 4'h2, 1'b0, 2'd0, 1'b0, 2'd0, 3'd1};
    tbl[3]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd1, 1'b0, 2'd0, 3'd1};
    tbl[4]  = '{4'hF, 1'b1, 1'b0, 4'h4, 1'b0, 2'd0, 1'b0, 2'd0, 3'd2};
    tbl[5]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 1'b0, 2'd0, 3'd2};
    tbl[6]  = '{4'hF, 1'b1, 1'b0, 4'h8, 1'b0, 2'd0, 1'b0, 2'd0, 3'd3};
    tbl[7]  = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd3, 1'b0, 2'd0, 3'd3};
    tbl[8]  = '{4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd4};
    tbl[9]  = '{4'hF, 1'b1, 1'b0, 4'h1, 1'b0, 2'd0, 1'b1, 2'd0, 3'd3};
    tbl[10] = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd3};
    tbl[11] = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd4};

    // Reset state.
    do_reset();
    #1;
    chk("rst req_read", 32'(req_read), 0);
    chk("rst wb_ap_start", 32'(wb_ap_start), 0);
    chk("rst outstanding", 32'(outstanding), 0);
    chk("rst done_valid", 32'(done_valid), 0);
    chk("rst err", 32'(err_spurious_done), 0);

    // Vector table: round-robin order and outstanding limit.
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].req, tbl[i].rdy, tbl[i].dn);
      chk($sformatf("tbl%0d req_read", i), 32'(req_read), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d start", i), 32'(wb_ap_start), 32'(tbl[i].st));
      if (tbl[i].st) chk($sformatf("tbl%0d grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
      chk($sformatf("tbl%0d done_valid", i), 32'(done_valid), 32'(tbl[i].dv));
      if (tbl[i].dv) chk($sformatf("tbl%0d done_id", i), 32'(done_id), 32'(tbl[i].did));
      chk($sformatf("tbl%0d outstanding", i), 32'(outstanding), 32'(tbl[i].outs));
    end

    // Single request, ready one cycle after start, then completion.
    do_reset();
    cyc(4'b0001, 1'b0, 1'b0);
    chk("single req_read", 32'(req_read), 32'h1);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("single start", 32'(wb_ap_start), 1);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("single outstanding", 32'(outstanding), 1);
    chk("single start low", 32'(wb_ap_start), 0);
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("single done_valid", 32'(done_valid), 1);
    chk("single done_id", 32'(done_id), 0);
    chk("single outstanding0", 32'(outstanding), 0);

    // Simultaneous ready and done with queue holding 1,2.
    do_reset();
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1);
    chk("simul grant_id", 32'(grant_id), 3);
    chk("simul outstanding pre", 32'(outstanding), 2);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("simul outstanding", 32'(outstanding), 2);
    chk("simul done_valid", 32'(done_valid), 1);
    chk("simul done_id", 32'(done_id), 1);
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("simul done_id2", 32'(done_id), 2);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("simul done_id3", 32'(done_id), 3);
    chk("simul outstanding0", 32'(outstanding), 0);

    // Spurious done: no completion, sticky error.
    do_reset();
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("spur done_valid", 32'(done_valid), 0);
    chk("spur err", 32'(err_spurious_done), 1);
    repeat (3) cyc(4'b0000, 1'b0, 1'b0);
    chk("spur err sticky", 32'(err_spurious_done), 1);

    // Async reset mid-START with two jobs outstanding.
    do_reset();
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0);
    chk("mid start", 32'(wb_ap_start), 1);
    chk("mid outstanding", 32'(outstanding), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst req_read", 32'(req_read), 0);
    chk("arst start", 32'(wb_ap_start), 0);
    chk("arst grant_id", 32'(grant_id), 0);
    chk("arst done_valid", 32'(done_valid), 0);
    chk("arst done_id", 32'(done_id), 0);
    chk("arst outstanding", 32'(outstanding), 0);
    chk("arst err", 32'(err_spurious_done), 0);
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    cyc(4'b1111, 1'b0, 1'b0);
    chk("arst first grant", 32'(req_read), 32'h1);
    cyc(4'b1111, 1'b1, 1'b0);
    chk("arst grant_id0", 32'(grant_id), 0);

    // Random traffic against the model, with an occasional reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      cyc(4'($urandom_range(0, 15)), 1'($urandom % 2), 1'($urandom % 4 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
